// File: rtl/trap_pkg.sv
// +------------------------------------------------------------------+
// | trap_pkg: shared types and constants for the trap sequencer       |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package trap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_LOAD   = 2'd2,
    ST_RETURN = 2'd3
  } trap_state_t;

  localparam int unsigned CAUSE_ILLEGAL    = 0;
  localparam int unsigned CAUSE_OVF        = 1;
  localparam int unsigned DEFAULT_VEC_BASE = 254;

endpackage

`default_nettype wire

// File: rtl/trap_prio_enc.sv
// +------------------------------------------------------------------+
// | trap_prio_enc: fixed-priority encoder, bit 0 has highest priority |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module trap_prio_enc #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic          valid,
  output logic [IW-1:0] index
);

  always_comb begin
    valid = |req;
    index = '0;
    // Scan downwards so the lowest set bit is the last (winning) write.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) index = IW'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/trap_sequencer.sv
// +------------------------------------------------------------------+
// | trap_sequencer: trap entry via vector table fetch, eret return    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module trap_sequencer
  import trap_pkg::*;
#(
  parameter int                XLEN     = 64,
  parameter int                NCAUSE   = 4,
  parameter int unsigned       VEC_BASE = DEFAULT_VEC_BASE,
  parameter int                VEC_W    = 8,
  parameter int                TIMEOUT  = 15,
  parameter logic [XLEN-1:0]   FALLBACK = '0,
  parameter int                CW       = (NCAUSE > 1) ? $clog2(NCAUSE) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCAUSE-1:0] cause_valid,
  input  logic [XLEN-1:0]   trap_pc,
  input  logic              eret,
  output logic              cpu_stall,
  output logic              mem_req,
  output logic [XLEN-1:0]   mem_addr,
  input  logic              mem_ready,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              pc_load,
  output logic [XLEN-1:0]   pc_value,
  output logic [XLEN-1:0]   epc,
  output logic [CW-1:0]     cause,
  output logic              in_handler,
  output logic              double_fault,
  output logic              timeout_err
);

  localparam int CNTW = $clog2(TIMEOUT + 1);

  trap_state_t     state, state_next;
  logic [CNTW-1:0] wait_cnt;
  logic            req_any;
  logic [CW-1:0]   req_idx;
  logic            accept, ret, take, expire;
  logic            unused_rdata_hi;

  assign unused_rdata_hi = ^mem_rdata[XLEN-1:VEC_W];

  trap_prio_enc #(.N(NCAUSE), .IW(CW)) u_prio (
    .req   (cause_valid),
    .valid (req_any),
    .index (req_idx)
  );

  assign mem_addr = (state == ST_FETCH) ? XLEN'(VEC_BASE) + XLEN'(cause) : '0;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = state;
    cpu_stall    = 1'b0;
    mem_req      = 1'b0;
    pc_load      = 1'b0;
    double_fault = 1'b0;
    accept       = 1'b0;
    ret          = 1'b0;
    take         = 1'b0;
    expire       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_handler) begin
          // eret has priority; any concurrent request is dropped as a double fault.
          double_fault = req_any;
          if (eret) begin
            ret        = 1'b1;
            state_next = ST_RETURN;
          end
        end else if (req_any) begin
          accept     = 1'b1;
          cpu_stall  = 1'b1;
          state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        cpu_stall = 1'b1;
        mem_req   = 1'b1;
        if (mem_ready) begin
          take       = 1'b1;
          state_next = ST_LOAD;
        end else if (wait_cnt == CNTW'(TIMEOUT - 1)) begin
          expire     = 1'b1;
          state_next = ST_LOAD;
        end
      end
      ST_LOAD, ST_RETURN: begin
        cpu_stall  = 1'b1;
        pc_load    = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      epc         <= '0;
      cause       <= '0;
      pc_value    <= '0;
      in_handler  <= 1'b0;
      timeout_err <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      if (accept) begin
        epc   <= trap_pc;
        cause <= req_idx;
      end
      if (ret) pc_value <= epc;
      if (state == ST_FETCH) begin
        wait_cnt <= (take || expire) ? '0 : wait_cnt + CNTW'(1);
        if (take) begin
          pc_value <= XLEN'(mem_rdata[VEC_W-1:0]);
        end else if (expire) begin
          pc_value    <= FALLBACK;
          timeout_err <= 1'b1;
        end
      end
      if (state == ST_LOAD)   in_handler <= 1'b1;
      if (state == ST_RETURN) in_handler <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_trap_sequencer.sv
// +------------------------------------------------------------------+
// | tb_trap_sequencer: randomized self-checking bench, trap sequencer |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module tb_trap_sequencer;

  localparam int XLEN = 64;
  localparam int NC   = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [NC-1:0]   cause_valid;
  logic [XLEN-1:0] trap_pc;
  logic            eret;
  logic            cpu_stall;
  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_ready;
  logic [XLEN-1:0] mem_rdata;
  logic            pc_load;
  logic [XLEN-1:0] pc_value;
  logic [XLEN-1:0] epc;
  logic [1:0]      cause;
  logic            in_handler;
  logic            double_fault;
  logic            timeout_err;

  int checks = 0;
  int errors = 0;

  // Reference-model state
  logic [63:0] m_epc;
  int          m_cause;
  bit          m_timeout;

  always #5 clk = ~clk;

  trap_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .cause_valid  (cause_valid),
    .trap_pc      (trap_pc),
    .eret         (eret),
    .cpu_stall    (cpu_stall),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata),
    .pc_load      (pc_load),
    .pc_value     (pc_value),
    .epc          (epc),
    .cause        (cause),
    .in_handler   (in_handler),
    .double_fault (double_fault),
    .timeout_err  (timeout_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int lowest_set(input logic [NC-1:0] v);
    for (int i = 0; i < NC; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One full trap entry; lat = idle cycles before mem_ready (>=15 means never ready).
  task automatic do_trap(input logic [NC-1:0] cv, input logic [63:0] pc,
                         input int lat, input logic [63:0] rdata);
    int          exit_k;
    logic [63:0] exp_pc;
    cause_valid = cv;
    trap_pc     = pc;
    #1;
    check("accept_stall", cpu_stall, 1);
    check("accept_no_df", double_fault, 0);
    next_cycle();
    cause_valid = '0;
    trap_pc     = $urandom;
    m_epc       = pc;
    m_cause     = lowest_set(cv);
    check("epc_saved", epc, m_epc);
    check("cause_saved", cause, m_cause);
    exit_k = (lat + 1 < 15) ? lat + 1 : 15;
    if (lat + 1 <= 15) exp_pc = rdata & 64'hFF;
    else begin
      exp_pc    = 64'h0;
      m_timeout = 1'b1;
    end
    for (int k = 1; k <= exit_k; k++) begin
      mem_ready = (k == lat + 1);
      mem_rdata = rdata;
      #1;
      check("fetch_req", mem_req, 1);
      check("fetch_addr", mem_addr, 64'd254 + 64'(m_cause));
      check("fetch_no_load", pc_load, 0);
      next_cycle();
    end
    mem_ready = 1'b0;
    mem_rdata = $urandom;
    #1;
    check("entry_load", pc_load, 1);
    check("entry_pc", pc_value, exp_pc);
    check("entry_stall", cpu_stall, 1);
    check("timeout_err", timeout_err, m_timeout);
    next_cycle();
    check("in_handler_set", in_handler, 1);
    check("idle_no_load", pc_load, 0);
    check("idle_no_req", mem_req, 0);
  endtask

  // Optional double-fault probe, then eret with an optional concurrent request.
  task automatic do_handler(input logic [NC-1:0] df_cv, input logic [NC-1:0] eret_cv);
    if (df_cv != 0) begin
      cause_valid = df_cv;
      trap_pc     = $urandom;
      #1;
      check("df_pulse", double_fault, 1);
      check("df_no_stall", cpu_stall, 0);
      next_cycle();
      cause_valid = '0;
      #1;
      check("df_epc_kept", epc, m_epc);
      check("df_cause_kept", cause, m_cause);
      check("df_no_req", mem_req, 0);
      check("df_no_load", pc_load, 0);
    end
    eret        = 1'b1;
    cause_valid = eret_cv;
    #1;
    check("eret_df", double_fault, (eret_cv != 0) ? 1 : 0);
    next_cycle();
    eret        = 1'b0;
    cause_valid = '0;
    #1;
    check("ret_load", pc_load, 1);
    check("ret_pc", pc_value, m_epc);
    check("ret_stall", cpu_stall, 1);
    check("ret_no_req", mem_req, 0);
    next_cycle();
    check("ret_left_handler", in_handler, 0);
    check("ret_single_load", pc_load, 0);
  endtask

  initial begin
    reset       = 1'b1;
    cause_valid = '0;
    trap_pc     = '0;
    eret        = 1'b0;
    mem_ready   = 1'b0;
    mem_rdata   = '0;
    m_epc       = '0;
    m_cause     = 0;
    m_timeout   = 1'b0;
    repeat (3) next_cycle();
    check("rst_stall", cpu_stall, 0);
    check("rst_req", mem_req, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_load", pc_load, 0);
    check("rst_pcv", pc_value, 0);
    check("rst_epc", epc, 0);
    check("rst_cause", cause, 0);
    check("rst_inh", in_handler, 0);
    check("rst_to", timeout_err, 0);
    reset = 1'b0;
    next_cycle();

    // eret outside a handler has no effect
    eret = 1'b1;
    next_cycle();
    eret = 1'b0;
    #1;
    check("stray_eret_load", pc_load, 0);
    check("stray_eret_stall", cpu_stall, 0);

    do_trap(4'b0010, 64'h40, 0, 64'h80);
    do_handler(4'b0001, 4'b0000);
    do_trap(4'b0011, 64'h1234, 0, 64'h1FF);
    do_handler(4'b0000, 4'b0100);
    do_trap(4'b1000, 64'hABCD, 14, 64'h3C);
    do_handler(4'b0000, 4'b0000);
    do_trap(4'b0100, 64'hBEEF, 99, 64'h77);
    do_handler(4'b1000, 4'b0000);

    for (int n = 0; n < 12; n++) begin
      logic [NC-1:0] cv, dcv, ecv;
      cv  = NC'($urandom_range(1, 15));
      dcv = ($urandom_range(0, 1) == 1) ? NC'($urandom_range(1, 15)) : '0;
      ecv = ($urandom_range(0, 1) == 1) ? NC'($urandom_range(1, 15)) : '0;
      do_trap(cv, {$urandom, $urandom}, $urandom_range(0, 18), {$urandom, $urandom});
      do_handler(dcv, ecv);
    end

    // Reset in the middle of a vector fetch
    cause_valid = 4'b0001;
    trap_pc     = 64'h5555;
    next_cycle();
    cause_valid = '0;
    #1;
    check("pre_rst_fetch", mem_req, 1);
    reset = 1'b1;
    next_cycle();
    check("mid_rst_req", mem_req, 0);
    check("mid_rst_load", pc_load, 0);
    check("mid_rst_epc", epc, 0);
    check("mid_rst_pcv", pc_value, 0);
    check("mid_rst_to", timeout_err, 0);
    check("mid_rst_stall", cpu_stall, 0);
    reset = 1'b0;
    #1;
    check("post_rst_addr", mem_addr, 0);
    next_cycle();
    check("post_rst_no_load", pc_load, 0);
    check("post_rst_inh", in_handler, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
